systolic_tile_sequencer: RTL and testbench

//  Drives one output-stationary systolic_array tile of C = A x B. Accepts one k-slice per beat
//  (column k of A, row k of B) and applies the diagonal input skew. Waits for the array's results,

---
 rtl/systolic_tile_sequencer.sv | 257 +++++++++++++++++++++++++
 tb/tb_systolic_tile_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : systolic_tile_sequencer
// Summary  : Feeds diagonally skewed k-slices into one output-stationary
//            systolic tile, then streams C out row-major and clears the tile.
//            Optional WAIT watchdog: define SYSTOLIC_SEQ_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module systolic_tile_sequencer #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  parameter int depth_p        = 16,
  parameter int timeout_p      = 64
) (
  input  logic                                             clk_i,
  input  logic                                             reset_i,
  input  logic [$clog2(depth_p+1)-1:0]                     k_len_i,
  input  logic [width_p*array_height_p-1:0]                a_i,
  input  logic [width_p*array_width_p-1:0]                 b_i,
  input  logic                                             ab_valid_i,
  output logic                                             ab_ready_o,
  output logic [width_p*array_height_p-1:0]                row_o,
  output logic [array_height_p-1:0]                        row_valid_o,
  input  logic [array_height_p-1:0]                        row_ready_i,
  output logic [width_p*array_width_p-1:0]                 col_o,
  output logic [array_width_p-1:0]                         col_valid_o,
  input  logic [array_width_p-1:0]                         col_ready_i,
  output logic                                             en_o,
  output logic [array_height_p-1:0]                        flush_o,
  input  logic [width_p*array_height_p*array_width_p-1:0]  z_i,
  input  logic [array_height_p*array_width_p-1:0]          z_valid_i,
  output logic [array_height_p*array_width_p-1:0]          z_yumi_o,
  output logic [width_p-1:0]                               res_o,
  output logic [((array_height_p > 1) ? $clog2(array_height_p) : 1)-1:0] res_row_o,
  output logic [((array_width_p > 1) ? $clog2(array_width_p) : 1)-1:0]   res_col_o,
  output logic                                             res_last_o,
  output logic                                             res_valid_o,
  input  logic                                             res_ready_i,
  output logic                                             busy_o,
  output logic                                             error_o
);

  localparam int c_h  = array_height_p;
  localparam int c_w  = array_width_p;
  localparam int c_kw = $clog2(depth_p+1);
  localparam int c_rw = (c_h > 1) ? $clog2(c_h) : 1;
  localparam int c_cw = (c_w > 1) ? $clog2(c_w) : 1;

  typedef enum logic [2:0] {
    s_idle  = 3'd0,
    s_load  = 3'd1,
    s_fill  = 3'd2,
    s_wait  = 3'd3,
    s_drain = 3'd4,
    s_clear = 3'd5
  } state_e;

  state_e          r_state;
  logic [c_kw-1:0] r_k;
  logic [c_kw-1:0] r_beats;
  logic [c_rw-1:0] r_row;
  logic [c_cw-1:0] r_col;
  logic            r_res_valid;
  logic            r_flush;

  logic            w_adv;
  logic            w_accept;
  logic            w_last;
  logic            w_pipe_busy;
  logic [c_h-1:0]  w_a_busy;
  logic [c_w-1:0]  w_b_busy;
  logic [c_kw-1:0] w_k_eff;
  logic [width_p-1:0] w_res;

  // A stalled lane holding valid data freezes every lane so the diagonal stays aligned.
  assign w_adv = (&(~row_valid_o | row_ready_i)) & (&(~col_valid_o | col_ready_i));

  assign ab_ready_o = w_adv & ((r_state == s_idle) |
                               ((r_state == s_load) & (r_beats < r_k)));
  assign w_accept   = ab_valid_i & ab_ready_o;
  assign w_pipe_busy = (|w_a_busy) | (|w_b_busy);

  always_comb begin
    w_k_eff = k_len_i;
    if (k_len_i == '0) begin
      w_k_eff = c_kw'(1);
    end else if (k_len_i > c_kw'(depth_p)) begin
      w_k_eff = c_kw'(depth_p);
    end
  end

  // Lane r of A is delayed r+1 stages; lane c of B likewise.
  for (genvar r = 0; r < c_h; r++) begin : g_a_lane
    logic [width_p*(r+1)-1:0] r_data;
    logic [r:0]               r_vld;
    logic [width_p-1:0]       w_in;

    assign w_in = w_accept ? a_i[width_p*r +: width_p] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_data <= '0;
        r_vld  <= '0;
      end else if (w_adv) begin
        r_data <= (r_data << width_p) | (width_p*(r+1))'(w_in);
        r_vld  <= (r_vld << 1) | (r+1)'(w_accept);
      end
    end

    assign row_o[width_p*r +: width_p] = r_data[width_p*r +: width_p];
    assign row_valid_o[r]              = r_vld[r];
    assign w_a_busy[r]                 = |r_vld;
  end

  for (genvar c = 0; c < c_w; c++) begin : g_b_lane
    logic [width_p*(c+1)-1:0] r_data;
    logic [c:0]               r_vld;
    logic [width_p-1:0]       w_in;

    assign w_in = w_accept ? b_i[width_p*c +: width_p] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        r_data <= '0;
        r_vld  <= '0;
      end else if (w_adv) begin
        r_data <= (r_data << width_p) | (width_p*(c+1))'(w_in);
        r_vld  <= (r_vld << 1) | (c+1)'(w_accept);
      end
    end

    assign col_o[width_p*c +: width_p] = r_data[width_p*c +: width_p];
    assign col_valid_o[c]              = r_vld[c];
    assign w_b_busy[c]                 = |r_vld;
  end

  assign w_last = (r_row == c_rw'(c_h-1)) & (r_col == c_cw'(c_w-1));

  // Array packs element (r,c) column-major; results leave row-major.
  always_comb begin
    w_res = '0;
    for (int r = 0; r < c_h; r++) begin
      for (int c = 0; c < c_w; c++) begin
        if ((r_row == c_rw'(r)) && (r_col == c_cw'(c))) begin
          w_res = z_i[width_p*(r+c*c_h) +: width_p];
        end
      end
    end
  end

`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  localparam int c_tw = $clog2(timeout_p+1);
  logic [c_tw-1:0] r_wait_cnt;
  logic            r_err;
`else
  if (timeout_p < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= s_idle;
      r_k         <= '0;
      r_beats     <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_res_valid <= 1'b0;
      r_flush     <= 1'b0;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        s_idle: begin
          if (w_accept) begin
            r_k     <= w_k_eff;
            r_beats <= c_kw'(1);
            r_state <= (w_k_eff == c_kw'(1)) ? s_fill : s_load;
          end
        end
        s_load: begin
          if (w_accept) begin
            r_beats <= r_beats + c_kw'(1);
            if ((r_beats + c_kw'(1)) == r_k) begin
              r_state <= s_fill;
            end
          end
        end
        s_fill: begin
          if (!w_pipe_busy) begin
            r_state <= s_wait;
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        s_wait: begin
          if (&z_valid_i) begin
            r_state     <= s_drain;
            r_res_valid <= 1'b1;
            r_row       <= '0;
            r_col       <= '0;
          end
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
          else if (r_wait_cnt == c_tw'(timeout_p-1)) begin
            r_err   <= 1'b1;
            r_flush <= 1'b1;
            r_state <= s_clear;
          end else begin
            r_wait_cnt <= r_wait_cnt + c_tw'(1);
          end
`endif
        end
        s_drain: begin
          if (r_res_valid && res_ready_i) begin
            if (w_last) begin
              r_res_valid <= 1'b0;
              r_flush     <= 1'b1;
              r_state     <= s_clear;
            end else if (r_col == c_cw'(c_w-1)) begin
              r_col <= '0;
              r_row <= r_row + c_rw'(1);
            end else begin
              r_col <= r_col + c_cw'(1);
            end
          end
        end
        s_clear: begin
          r_flush <= 1'b0;
          r_state <= s_idle;
        end
        default: begin
          r_state <= s_idle;
        end
      endcase
    end
  end

  assign en_o        = 1'b1;
  assign flush_o     = {c_h{r_flush}};
  assign z_yumi_o    = {(c_h*c_w){r_flush}};
  assign res_o       = w_res;
  assign res_row_o   = r_row;
  assign res_col_o   = r_col;
  assign res_valid_o = r_res_valid;
  assign res_last_o  = r_res_valid & w_last;
  assign busy_o      = (r_state != s_idle);
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
  assign error_o     = r_err;
`else
  assign error_o     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_tile_sequencer
// Summary  : Directed + randomized bench; the bench plays the systolic array
//            from the lane streams and checks C against its own A x B.
// Revision : 1.0  initial release
// ============================================================================
module tb_systolic_tile_sequencer;
  localparam int WD = 32;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int D  = 16;
  localparam int KW = $clog2(D+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic [KW-1:0]     k_len_i;
  logic [WD*H-1:0]   a_i;
  logic [WD*W-1:0]   b_i;
  logic              ab_valid_i, ab_ready_o;
  logic [WD*H-1:0]   row_o;
  logic [H-1:0]      row_valid_o, row_ready_i;
  logic [WD*W-1:0]   col_o;
  logic [W-1:0]      col_valid_o, col_ready_i;
  logic              en_o;
  logic [H-1:0]      flush_o;
  logic [WD*H*W-1:0] z_i;
  logic [H*W-1:0]    z_valid_i, z_yumi_o;
  logic [WD-1:0]     res_o;
  logic              res_row_o, res_col_o;
  logic              res_last_o, res_valid_o, res_ready_i, busy_o, error_o;

  systolic_tile_sequencer #(
    .width_p(WD), .array_width_p(W), .array_height_p(H), .depth_p(D), .timeout_p(64)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .k_len_i(k_len_i), .a_i(a_i), .b_i(b_i),
    .ab_valid_i(ab_valid_i), .ab_ready_o(ab_ready_o),
    .row_o(row_o), .row_valid_o(row_valid_o), .row_ready_i(row_ready_i),
    .col_o(col_o), .col_valid_o(col_valid_o), .col_ready_i(col_ready_i),
    .en_o(en_o), .flush_o(flush_o), .z_i(z_i), .z_valid_i(z_valid_i), .z_yumi_o(z_yumi_o),
    .res_o(res_o), .res_row_o(res_row_o), .res_col_o(res_col_o), .res_last_o(res_last_o),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .busy_o(busy_o), .error_o(error_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ma [H][D];
  logic [31:0] mb [D][W];
  logic [31:0] cap_a [H][D+1];
  logic [31:0] cap_b [W][D+1];
  int          na [H];
  int          nb [W];
  logic        cap_clr;
  logic        tb_adv;

  // A lane element is consumed only when every valid lane is ready.
  assign tb_adv = (&(~row_valid_o | row_ready_i)) & (&(~col_valid_o | col_ready_i));

  always @(posedge clk) begin
    if (cap_clr) begin
      for (int r = 0; r < H; r++) na[r] <= 0;
      for (int c = 0; c < W; c++) nb[c] <= 0;
    end else if (!reset_i && tb_adv) begin
      for (int r = 0; r < H; r++) begin
        if (row_valid_o[r]) begin
          if (na[r] <= D) cap_a[r][na[r]] <= row_o[WD*r +: WD];
          na[r] <= na[r] + 1;
        end
      end
      for (int c = 0; c < W; c++) begin
        if (col_valid_o[c]) begin
          if (nb[c] <= D) cap_b[c][nb[c]] <= col_o[WD*c +: WD];
          nb[c] <= nb[c] + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_c(input int r, input int c, input int k);
    logic [31:0] s = 0;
    for (int j = 0; j < k; j++) s = s + ma[r][j] * mb[j][c];
    return s;
  endfunction

  function automatic logic [31:0] arr_c(input int r, input int c, input int k);
    logic [31:0] s = 0;
    for (int j = 0; j < k; j++) s = s + cap_a[r][j] * cap_b[c][j];
    return s;
  endfunction

  function automatic bit caps_full(input int k);
    bit ok = 1;
    for (int r = 0; r < H; r++) if (na[r] != k) ok = 0;
    for (int c = 0; c < W; c++) if (nb[c] != k) ok = 0;
    return ok;
  endfunction

  task automatic load_t2();
    ma[0][0] = -32'sd37; ma[0][1] = 32'sd44;
    ma[1][0] = 32'sd10;  ma[1][1] = 32'sd960;
    mb[0][0] = 32'sd83;  mb[0][1] = 32'sd99;
    mb[1][0] = 32'sd22;  mb[1][1] = -32'sd1;
  endtask

  task automatic clear_caps();
    cap_clr = 1'b1;
    @(posedge clk); #1;
    cap_clr = 1'b0;
  endtask

  // Runs one tile from the current posedge+1 point. k=0 exercises the "0 means 1" rule.
  task automatic run_tile(input int k, input int beat0, input bit rnd_rdy, input int res_mode,
                          input int stop_after, input bit give_z);
    int keff = (k == 0) ? 1 : k;
    int beat = beat0;
    int got = 0, cyc = 0, zdly = 0, dcyc = 0;
    bit done = 0, hold = 0;
    logic [33:0] held;
    while (!done && cyc < 3000) begin
      ab_valid_i = (beat < keff) && ($urandom_range(0, 4) != 0);
      for (int r = 0; r < H; r++) a_i[WD*r +: WD] = (beat < keff) ? ma[r][beat] : 32'd0;
      for (int c = 0; c < W; c++) b_i[WD*c +: WD] = (beat < keff) ? mb[beat][c] : 32'd0;
      k_len_i     = KW'(k);
      row_ready_i = rnd_rdy ? H'($urandom) : '1;
      col_ready_i = rnd_rdy ? W'($urandom) : '1;
      case (res_mode)
        0:       res_ready_i = 1'b1;
        1:       res_ready_i = (dcyc % 3 == 0);
        default: res_ready_i = 1'($urandom_range(0, 1));
      endcase
      if (res_valid_o) dcyc++;
      if (beat >= keff && caps_full(keff)) begin
        if (!give_z) done = 1;
        else if (z_valid_i == '0) begin
          zdly++;
          if (zdly > 2) begin
            for (int r = 0; r < H; r++)
              for (int c = 0; c < W; c++) z_i[WD*(r+c*H) +: WD] = arr_c(r, c, keff);
            z_valid_i = '1;
          end
        end
      end
      @(negedge clk);
      if (ab_valid_i && ab_ready_o) beat++;
      if (hold) chk("res_hold", {res_valid_o, res_row_o, res_col_o, res_o}, {1'b1, held});
      hold = 0;
      if (res_valid_o && !done) begin
        if (!res_ready_i) begin
          hold = 1;
          held = {res_row_o, res_col_o, res_o};
        end else begin
          chk("res_val", res_o, exp_c(got / W, got % W, keff));
          chk("res_idx", {res_row_o, res_col_o}, {1'(got / W), 1'(got % W)});
          chk("res_last", res_last_o, (got == H*W-1));
          got++;
          if (got == H*W || (stop_after > 0 && got == stop_after)) done = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("tile_done", done, 1'b1);
    if (give_z && stop_after == 0) begin
      chk("n_res", got, H*W);
      chk("clear_pulse", {busy_o, flush_o, z_yumi_o}, {1'b1, 2'b11, 4'b1111});
      z_valid_i   = '0;
      ab_valid_i  = 1'b0;
      row_ready_i = '1;
      col_ready_i = '1;
      clear_caps();
      chk("post_clear", {busy_o, flush_o, z_yumi_o, res_valid_o, ab_ready_o},
          {1'b0, 2'b00, 4'b0000, 1'b0, 1'b1});
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    ab_valid_i = 1'b0; z_valid_i = '0; cap_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    cap_clr = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1; cap_clr = 1'b1; k_len_i = '0; a_i = '0; b_i = '0; ab_valid_i = 1'b0;
    row_ready_i = '1; col_ready_i = '1; z_i = '0; z_valid_i = '0; res_ready_i = 1'b1;

    // Test 1: reset / idle values
    do_reset();
    chk("rst_valids", {row_valid_o, col_valid_o, flush_o, z_yumi_o}, '0);
    chk("rst_ctrl", {res_valid_o, busy_o, error_o, en_o, ab_ready_o},
        {1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

    // Test 2: reference tile
    load_t2();
    run_tile(2, 0, 0, 0, 0, 1);

    // Test 3: skew timing and lane freeze
    ma[0][0] = 32'd5; ma[1][0] = 32'd7; mb[0][0] = 32'd2; mb[0][1] = 32'd3;
    ab_valid_i = 1'b1; k_len_i = KW'(1);
    a_i = {32'd7, 32'd5}; b_i = {32'd3, 32'd2};
    #1 chk("skew_ready", ab_ready_o, 1'b1);
    @(posedge clk); #1;
    ab_valid_i = 1'b0;
    chk("skew_t1_vld", {row_valid_o, col_valid_o}, {2'b01, 2'b01});
    chk("skew_t1_dat", {row_o[31:0], col_o[31:0]}, {32'd5, 32'd2});
    row_ready_i = 2'b01;
    @(posedge clk); #1;
    chk("skew_t2_vld", {row_valid_o, col_valid_o}, {2'b10, 2'b10});
    chk("skew_t2_dat", {row_o[63:32], col_o[63:32]}, {32'd7, 32'd3});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("freeze", {row_valid_o, col_valid_o, row_o[63:32], ab_ready_o},
          {2'b10, 2'b10, 32'd7, 1'b0});
    end
    row_ready_i = '1;
    run_tile(1, 1, 0, 0, 0, 1);

    // Test 4: result backpressure 1,0,0,1...
    load_t2();
    run_tile(2, 0, 0, 1, 0, 1);

    // Test 5: reset during DRAIN, then a clean rerun
    run_tile(2, 0, 0, 0, 2, 1);
    reset_i = 1'b1;
    #1;
    chk("mid_rst", {res_valid_o, busy_o, row_valid_o, col_valid_o}, '0);
    z_valid_i = '0;
    cap_clr = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    cap_clr = 1'b0;
    run_tile(2, 0, 0, 0, 0, 1);

    // Randomized tiles with lane and result stalls, incl. K=16 and K=0
    for (int t = 0; t < 5; t++) begin
      int k = (t == 0) ? 16 : (t == 1) ? 0 : int'($urandom_range(1, 16));
      for (int j = 0; j < D; j++) begin
        for (int r = 0; r < H; r++) ma[r][j] = $urandom;
        for (int c = 0; c < W; c++) mb[j][c] = $urandom;
      end
      run_tile(k, 0, 1, 2, 0, 1);
    end

    // Test 6: no results ever arrive
    load_t2();
    run_tile(2, 0, 0, 0, 0, 0);
`ifdef SYSTOLIC_SEQ_TIMEOUT_EN
    begin
      int waited = 0;
      while (!error_o && waited < 100) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("to_err", error_o, 1'b1);
      chk("to_clear", {flush_o, z_yumi_o, res_valid_o}, {2'b11, 4'b1111, 1'b0});
      @(posedge clk); #1;
      chk("to_idle", {busy_o, error_o}, {1'b0, 1'b1});
    end
`else
    repeat (200) @(posedge clk);
    #1;
    chk("wait_forever", {busy_o, error_o, res_valid_o, flush_o}, {1'b1, 1'b0, 1'b0, 2'b00});
`endif
    do_reset();
    chk("final_rst", {busy_o, error_o}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
